// File: rtl/pong_link_pkg.sv
// Shared constants, field widths, FSM encoding and payload packing for the pong inter-board link.
// FRAME_BYTES grows to 9 when PONG_FRAMER_CHECKSUM_EN is defined.
package pong_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int PAYLOAD_BYTES = 7;
    localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;
`ifdef PONG_FRAMER_CHECKSUM_EN
    localparam int FRAME_BYTES = PAYLOAD_BYTES + 2;
`else
    localparam int FRAME_BYTES = PAYLOAD_BYTES + 1;
`endif

    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int SCORE_W = 4;
    localparam int STATE_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } fsm_state_t;

    // Most significant byte goes on the wire first.
    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [STATE_W-1:0] st,
        input logic [SCORE_W-1:0] score1,
        input logic [SCORE_W-1:0] score2,
        input logic [X_W-1:0]     xb,
        input logic [Y_W-1:0]     yb,
        input logic [Y_W-1:0]     yp1,
        input logic [Y_W-1:0]     yp2
    );
        return {5'b0, st, score1, score2, xb, yb, yp1, yp2};
    endfunction

endpackage

// File: rtl/pong_state_framer_if.sv
// Valid/ready byte stream from the state framer into the UART transmitter.
interface pong_state_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/pong_state_framer.sv
// Snapshots game state every TICK_DIV timing ticks and streams it as SYNC + 7 payload bytes;
// PONG_FRAMER_CHECKSUM_EN appends an XOR checksum byte. First byte valid one cycle after the send tick.
module pong_state_framer
    import pong_link_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic [Y_W-1:0]     y_player1,
    input  logic [Y_W-1:0]     y_player2,
    input  logic [X_W-1:0]     x_ball,
    input  logic [Y_W-1:0]     y_ball,
    input  logic [SCORE_W-1:0] player1_score,
    input  logic [SCORE_W-1:0] player2_score,
    input  logic [STATE_W-1:0] state,
    pong_state_framer_if.master tx,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_drop
);

    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(PAYLOAD_BYTES - 1);

    fsm_state_t           r_state, w_state_nx;
    logic [2:0]           r_idx, w_idx_nx;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [7:0]           r_div;
    logic                 r_done, r_drop;
    logic                 w_send_tick, w_capture, w_last_accept;
    logic [7:0]           w_pay_byte;

    assign w_send_tick = timing_tick && (r_div == DIV_LAST);
    assign frame_done  = r_done;
    assign frame_drop  = r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // The divider keeps counting while a frame is in flight so tick phase never drifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= 8'd0;
            r_payload <= '0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            if (timing_tick)
                r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
            if (w_capture)
                r_payload <= pack_payload(state, player1_score, player2_score,
                                          x_ball, y_ball, y_player1, y_player2);
            r_done <= w_last_accept;
            r_drop <= w_send_tick && busy;
        end
    end

    always_comb begin
        w_pay_byte = 8'h00;
        case (r_idx)
            3'd0:    w_pay_byte = r_payload[55:48];
            3'd1:    w_pay_byte = r_payload[47:40];
            3'd2:    w_pay_byte = r_payload[39:32];
            3'd3:    w_pay_byte = r_payload[31:24];
            3'd4:    w_pay_byte = r_payload[23:16];
            3'd5:    w_pay_byte = r_payload[15:8];
            3'd6:    w_pay_byte = r_payload[7:0];
            default: w_pay_byte = 8'h00;
        endcase
    end

`ifdef PONG_FRAMER_CHECKSUM_EN
    logic [7:0] w_csum;
    assign w_csum = r_payload[55:48] ^ r_payload[47:40] ^ r_payload[39:32] ^ r_payload[31:24]
                  ^ r_payload[23:16] ^ r_payload[15:8] ^ r_payload[7:0];
`endif

    // Outside IDLE tx_valid is always high, so tx_ready alone marks a transfer.
    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_capture     = 1'b0;
        w_last_accept = 1'b0;
        tx.tx_valid   = 1'b0;
        tx.tx_data    = 8'h00;
        busy          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_send_tick) begin
                    w_state_nx = SYNC;
                    w_capture  = 1'b1;
                end
            end
            SYNC: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = SYNC_BYTE;
                busy        = 1'b1;
                if (tx.tx_ready) begin
                    w_state_nx = PAYLOAD;
                    w_idx_nx   = 3'd0;
                end
            end
            PAYLOAD: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = w_pay_byte;
                busy        = 1'b1;
                if (tx.tx_ready) begin
                    if (r_idx == IDX_LAST) begin
`ifdef PONG_FRAMER_CHECKSUM_EN
                        w_state_nx = CSUM;
`else
                        w_state_nx    = IDLE;
                        w_last_accept = 1'b1;
`endif
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end
            end
`ifdef PONG_FRAMER_CHECKSUM_EN
            CSUM: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = w_csum;
                busy        = 1'b1;
                if (tx.tx_ready) begin
                    w_state_nx    = IDLE;
                    w_last_accept = 1'b1;
                end
            end
`endif
            default: w_state_nx = IDLE;
        endcase
    end

endmodule
